// File: rtl/imem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// imem_ctrl_pkg
// Shared definitions for the instruction-memory controller: controller state
// encoding, the NOP instruction driven whenever no fetch response is valid,
// and the default memory geometry.
// -----------------------------------------------------------------------------
package imem_ctrl_pkg;

   localparam int          DEPTH_DEF = 64;
   localparam int          AW_DEF    = 6;
   localparam logic [31:0] NOP       = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_RUN   = 2'd2,
      ST_FAULT = 2'd3
   } state_e;

endpackage

// File: rtl/imem_ctrl.sv
// -----------------------------------------------------------------------------
// imem_ctrl
// Controller in front of an external single-port-write / synchronous-read
// instruction memory. It loads a program from a streaming loader, then serves
// instruction fetches with a fixed one-cycle latency, and traps on misaligned
// or out-of-range fetch addresses.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   run_en                   IDLE: start fetch service without loading
//   ld_start, ld_len         begin a program load of ld_len words (0 = DEPTH)
//   ld_valid, ld_data        loader word handshake / data
//   ld_ready                 controller accepts a load word this cycle
//   ld_done                  one-cycle pulse after the last load word
//   if_req, if_addr          fetch request / byte PC address
//   if_valid, if_instr       fetch response / instruction (NOP when invalid)
//   stall                    pipeline must hold PC and IF/ID
//   fault, fault_addr        sticky fetch fault / captured PC
//   mem_we, mem_waddr,
//   mem_wdata                memory write port
//   mem_raddr, mem_rdata     memory read port (data one cycle after address)
// -----------------------------------------------------------------------------
module imem_ctrl
   import imem_ctrl_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = AW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          run_en,
   input  logic          ld_start,
   input  logic [6:0]    ld_len,
   input  logic          ld_valid,
   input  logic [31:0]   ld_data,
   output logic          ld_ready,
   output logic          ld_done,
   input  logic          if_req,
   input  logic [31:0]   if_addr,
   output logic          if_valid,
   output logic [31:0]   if_instr,
   output logic          stall,
   output logic          fault,
   output logic [31:0]   fault_addr,
   output logic          mem_we,
   output logic [AW-1:0] mem_waddr,
   output logic [31:0]   mem_wdata,
   output logic [AW-1:0] mem_raddr,
   input  logic [31:0]   mem_rdata
);

   localparam int LW = AW + 1;

   state_e        state_r;
   logic [AW-1:0] wcnt_r;
   logic [LW-1:0] len_r;
   logic          fault_r;
   logic [31:0]   fault_addr_r;
   logic          ld_done_r;
   logic          if_valid_r;

   logic          addr_ok_s;
   logic          last_s;
   logic          load_s;
   logic [LW-1:0] len_sel_s;

   // A fetch address is usable only if word aligned and inside the memory.
   function automatic logic addr_ok(input logic [31:0] a);
      return (a[1:0] == 2'b00) && ((a >> (AW + 2)) == 32'd0);
   endfunction

   // Requested load length; zero (and anything beyond the memory) means a full load.
   function automatic logic [LW-1:0] len_sel(input logic [6:0] n);
      if ((n == 7'd0) || ({25'd0, n} > $unsigned(DEPTH))) begin
         return LW'(DEPTH);
      end else begin
         return LW'(n);
      end
   endfunction

   // Request qualification and end-of-load detection.
   always_comb begin
      addr_ok_s = addr_ok(if_addr);
      len_sel_s = len_sel(ld_len);
      last_s    = ({1'b0, wcnt_r} == (len_r - LW'(1)));
      if ((state_r == ST_LOAD) && !rst) begin
         load_s = 1'b1;
      end else begin
         load_s = 1'b0;
      end
   end

   // Controller FSM with its registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         wcnt_r       <= {AW{1'b0}};
         len_r        <= LW'(DEPTH);
         fault_r      <= 1'b0;
         fault_addr_r <= 32'h0000_0000;
         ld_done_r    <= 1'b0;
         if_valid_r   <= 1'b0;
      end else begin
         ld_done_r  <= 1'b0;
         if_valid_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (ld_start) begin
                  state_r <= ST_LOAD;
                  len_r   <= len_sel_s;
                  wcnt_r  <= {AW{1'b0}};
               end else if (run_en) begin
                  state_r <= ST_RUN;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_LOAD: begin
               // ld_start is deliberately not looked at here.
               if (ld_valid) begin
                  if (last_s) begin
                     wcnt_r    <= {AW{1'b0}};
                     ld_done_r <= 1'b1;
                     state_r   <= ST_RUN;
                  end else begin
                     wcnt_r <= wcnt_r + AW'(1);
                  end
               end else begin
                  wcnt_r <= wcnt_r;
               end
            end
            ST_RUN: begin
               // A reload wins over a same-cycle fetch, which is dropped.
               if (ld_start) begin
                  state_r <= ST_LOAD;
                  len_r   <= len_sel_s;
                  wcnt_r  <= {AW{1'b0}};
               end else if (if_req) begin
                  if (addr_ok_s) begin
                     if_valid_r <= 1'b1;
                  end else begin
                     state_r      <= ST_FAULT;
                     fault_r      <= 1'b1;
                     fault_addr_r <= if_addr;
                  end
               end else begin
                  state_r <= ST_RUN;
               end
            end
            ST_FAULT: begin
               if (ld_start) begin
                  state_r <= ST_LOAD;
                  len_r   <= len_sel_s;
                  wcnt_r  <= {AW{1'b0}};
                  fault_r <= 1'b0;
               end else begin
                  state_r <= ST_FAULT;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               fault_r <= 1'b0;
               wcnt_r  <= {AW{1'b0}};
            end
         endcase
      end
   end

   assign ld_ready   = load_s;
   assign ld_done    = ld_done_r;
   assign stall      = (state_r != ST_RUN);
   assign fault      = fault_r;
   assign fault_addr = fault_addr_r;
   assign if_valid   = if_valid_r;
   // Memory data is already registered inside the RAM; mask it to NOP so no
   // stale word leaks out when there is no response.
   assign if_instr   = if_valid_r ? mem_rdata : NOP;

   assign mem_we     = load_s && ld_valid;
   assign mem_waddr  = wcnt_r;
   assign mem_wdata  = ld_data;
   assign mem_raddr  = if_addr[AW+1:2];

endmodule

// File: tb/tb_imem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_ctrl
// Directed bench for imem_ctrl with a behavioural synchronous-read RAM.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_imem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        run_en;
   logic        ld_start;
   logic [6:0]  ld_len;
   logic        ld_valid;
   logic [31:0] ld_data;
   logic        ld_ready;
   logic        ld_done;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_valid;
   logic [31:0] if_instr;
   logic        stall;
   logic        fault;
   logic [31:0] fault_addr;
   logic        mem_we;
   logic [5:0]  mem_waddr;
   logic [31:0] mem_wdata;
   logic [5:0]  mem_raddr;
   logic [31:0] mem_rdata;

   logic [31:0] mem [0:63];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   imem_ctrl #(.DEPTH(64), .AW(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .run_en     (run_en),
      .ld_start   (ld_start),
      .ld_len     (ld_len),
      .ld_valid   (ld_valid),
      .ld_data    (ld_data),
      .ld_ready   (ld_ready),
      .ld_done    (ld_done),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_valid   (if_valid),
      .if_instr   (if_instr),
      .stall      (stall),
      .fault      (fault),
      .fault_addr (fault_addr),
      .mem_we     (mem_we),
      .mem_waddr  (mem_waddr),
      .mem_wdata  (mem_wdata),
      .mem_raddr  (mem_raddr),
      .mem_rdata  (mem_rdata)
   );

   // External instruction RAM: one write port, synchronous read.
   always @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
      mem_rdata <= mem[mem_raddr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; run_en = 1'b0; ld_start = 1'b0; ld_len = 7'd0;
      ld_valid = 1'b0; ld_data = 32'h0; if_req = 1'b0; if_addr = 32'h0;
      next(); next();
      // Reset state, with load/fetch inputs active to show reset dominates.
      ld_valid = 1'b1; if_req = 1'b1; ld_start = 1'b1;
      neg();
      chk("rst_stall", {31'd0, stall}, 32'd1);
      chk("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
      chk("rst_ld_done", {31'd0, ld_done}, 32'd0);
      chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_if_instr", if_instr, 32'h0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_fault", {31'd0, fault}, 32'd0);
      chk("rst_fault_addr", fault_addr, 32'h0);
      next();
      rst = 1'b0; ld_valid = 1'b0; if_req = 1'b0; ld_start = 1'b0;
      next();

      // Load four words; ld_start has priority over run_en in IDLE.
      ld_start = 1'b1; ld_len = 7'd4; run_en = 1'b1;
      neg();
      chk("idle_ld_ready", {31'd0, ld_ready}, 32'd0);
      next();
      ld_start = 1'b0; run_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ld_valid = 1'b1; ld_data = 32'hA0A0_0000 + 32'(i);
         neg();
         chk("ld4_ready", {31'd0, ld_ready}, 32'd1);
         chk("ld4_we", {31'd0, mem_we}, 32'd1);
         chk("ld4_waddr", {26'd0, mem_waddr}, 32'(i));
         chk("ld4_wdata", mem_wdata, 32'hA0A0_0000 + 32'(i));
         chk("ld4_done_early", {31'd0, ld_done}, 32'd0);
         next();
      end
      ld_valid = 1'b0;
      neg();
      chk("ld4_done", {31'd0, ld_done}, 32'd1);
      chk("ld4_run_stall", {31'd0, stall}, 32'd0);
      chk("ld4_ready_off", {31'd0, ld_ready}, 32'd0);
      next();
      neg();
      chk("ld4_done_pulse", {31'd0, ld_done}, 32'd0);
      next();

      // Back-to-back fetches at 0x00, 0x04, 0x08.
      if_req = 1'b1; if_addr = 32'h0;
      neg();
      chk("f0_raddr", {26'd0, mem_raddr}, 32'd0);
      chk("f0_valid", {31'd0, if_valid}, 32'd0);
      next();
      if_addr = 32'h4;
      neg();
      chk("f1_valid", {31'd0, if_valid}, 32'd1);
      chk("f1_instr", if_instr, 32'hA0A0_0000);
      next();
      if_addr = 32'h8;
      neg();
      chk("f2_instr", if_instr, 32'hA0A0_0001);
      next();
      if_req = 1'b0;
      neg();
      chk("f3_valid", {31'd0, if_valid}, 32'd1);
      chk("f3_instr", if_instr, 32'hA0A0_0002);
      next();
      neg();
      chk("f4_valid", {31'd0, if_valid}, 32'd0);
      chk("f4_nop", if_instr, 32'h0);
      next();

      // Misaligned fetch traps; reload clears the fault.
      if_req = 1'b1; if_addr = 32'h6;
      next();
      if_req = 1'b0;
      neg();
      chk("mis_fault", {31'd0, fault}, 32'd1);
      chk("mis_fault_addr", fault_addr, 32'h0000_0006);
      chk("mis_stall", {31'd0, stall}, 32'd1);
      chk("mis_no_valid", {31'd0, if_valid}, 32'd0);
      next();
      ld_valid = 1'b1; ld_data = 32'hDEAD_0000;
      neg();
      chk("fault_no_we", {31'd0, mem_we}, 32'd0);
      chk("fault_sticky", {31'd0, fault}, 32'd1);
      next();
      ld_valid = 1'b0; ld_start = 1'b1; ld_len = 7'd1;
      next();
      ld_start = 1'b0; ld_valid = 1'b1; ld_data = 32'hB0B0_0000;
      neg();
      chk("reload_fault_clr", {31'd0, fault}, 32'd0);
      chk("reload_ready", {31'd0, ld_ready}, 32'd1);
      next();
      ld_valid = 1'b0;
      neg();
      chk("len1_done", {31'd0, ld_done}, 32'd1);
      next();
      if_req = 1'b1; if_addr = 32'h0;
      next();
      if_req = 1'b0;
      neg();
      chk("len1_fetch", if_instr, 32'hB0B0_0000);
      next();

      // Out-of-range fetch just past the memory.
      if_req = 1'b1; if_addr = 32'h100;
      next();
      if_req = 1'b0;
      neg();
      chk("oor_fault", {31'd0, fault}, 32'd1);
      chk("oor_fault_addr", fault_addr, 32'h0000_0100);
      chk("oor_no_valid", {31'd0, if_valid}, 32'd0);
      next();

      // Load two words; a second ld_start during LOAD must not change the length.
      ld_start = 1'b1; ld_len = 7'd2;
      next();
      ld_start = 1'b1; ld_len = 7'd1; ld_valid = 1'b1; ld_data = 32'hC0C0_0000;
      neg();
      chk("ign_start_we", {31'd0, mem_we}, 32'd1);
      next();
      ld_start = 1'b0; ld_data = 32'hC0C0_0001;
      neg();
      chk("ign_start_no_done", {31'd0, ld_done}, 32'd0);
      chk("ign_start_waddr", {26'd0, mem_waddr}, 32'd1);
      next();
      ld_valid = 1'b0;
      neg();
      chk("len2_done", {31'd0, ld_done}, 32'd1);
      next();

      // Fetch, then ld_start together with a new fetch.
      if_req = 1'b1; if_addr = 32'h4;
      next();
      ld_start = 1'b1; ld_len = 7'd5; if_addr = 32'h0;
      neg();
      chk("race_prev_valid", {31'd0, if_valid}, 32'd1);
      chk("race_prev_instr", if_instr, 32'hC0C0_0001);
      next();
      ld_start = 1'b0; if_req = 1'b0;
      neg();
      chk("race_ready", {31'd0, ld_ready}, 32'd1);
      chk("race_dropped", {31'd0, if_valid}, 32'd0);
      chk("race_stall", {31'd0, stall}, 32'd1);

      // Two of five words, then reset with a word pending.
      for (int i = 0; i < 2; i++) begin
         ld_valid = 1'b1; ld_data = 32'hD0D0_0000 + 32'(i);
         next();
      end
      rst = 1'b1; ld_data = 32'hD0D0_0002;
      neg();
      chk("abort_we", {31'd0, mem_we}, 32'd0);
      chk("abort_ready", {31'd0, ld_ready}, 32'd0);
      next();
      rst = 1'b0; ld_valid = 1'b0;
      neg();
      chk("abort_no_done", {31'd0, ld_done}, 32'd0);
      chk("abort_idle_stall", {31'd0, stall}, 32'd1);
      next();

      // run_en from IDLE; memory survives reset.
      run_en = 1'b1;
      next();
      run_en = 1'b0; if_req = 1'b1; if_addr = 32'h4;
      neg();
      chk("runen_stall", {31'd0, stall}, 32'd0);
      next();
      if_req = 1'b0;
      neg();
      chk("kept_mem", if_instr, 32'hD0D0_0001);
      next();

      // Full-depth load with ld_len = 0.
      ld_start = 1'b1; ld_len = 7'd0;
      next();
      ld_start = 1'b0;
      for (int i = 0; i < 64; i++) begin
         ld_valid = 1'b1; ld_data = 32'h1000_0000 + 32'(i);
         neg();
         chk("full_waddr", {26'd0, mem_waddr}, 32'(i));
         chk("full_done_early", {31'd0, ld_done}, 32'd0);
         next();
      end
      ld_valid = 1'b0;
      neg();
      chk("full_done", {31'd0, ld_done}, 32'd1);
      next();
      if_req = 1'b1; if_addr = 32'hFC;
      next();
      if_addr = 32'h0;
      neg();
      chk("full_last_word", if_instr, 32'h1000_003F);
      next();
      if_req = 1'b0;
      neg();
      chk("full_first_word", if_instr, 32'h1000_0000);
      chk("full_no_fault", {31'd0, fault}, 32'd0);
      next();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imem_ctrl.md
IMEM_CTRL -- requirements
Module: imem_ctrl

Interface
REQ-001 Parameter DEPTH, default 64: instruction words held in the attached instruction memory.
REQ-002 Parameter AW, default 6: word-index width, log2(DEPTH).
REQ-003 clk  input  1: single clock, all state on rising edge.
REQ-004 rst  input  1: synchronous, active-high reset.
REQ-005 run_en  input  1: in IDLE, start fetch service without loading.
REQ-006 ld_start  input  1: pulse; begin program load.
REQ-007 ld_len  input  7: words to load, sampled on accepted ld_start; 0 means DEPTH.
REQ-008 ld_valid / ld_data  input  1 / 32: loader word handshake, data.
REQ-009 ld_ready  output  1: controller accepts a load word this cycle.
REQ-010 ld_done  output  1: one-cycle pulse after the last load word is written.
REQ-011 if_req / if_addr  input  1 / 32: fetch request, byte PC address.
REQ-012 if_valid / if_instr  output  1 / 32: fetch response, instruction.
REQ-013 stall  output  1: pipeline must hold PC and IF/ID register.
REQ-014 fault / fault_addr  output  1 / 32: sticky fetch fault, captured PC.
REQ-015 mem_we, mem_waddr[AW-1:0], mem_wdata[31:0]  output: memory write port.
REQ-016 mem_raddr[AW-1:0]  output, mem_rdata[31:0]  input: memory read port, one-cycle synchronous read.

Function
REQ-017 States IDLE, LOAD, RUN, FAULT; stall = 1 in every state except RUN.
REQ-018 IDLE: ld_start -> LOAD; else run_en -> RUN; ld_start has priority.
REQ-019 LOAD: ld_ready = 1; each ld_valid&&ld_ready writes ld_data at word index wcnt (mem_we = 1 that cycle), then wcnt increments.
REQ-020 LOAD: the write with wcnt = len-1 asserts ld_done the next cycle and moves to RUN; wcnt clears to 0.
REQ-021 ld_start while in LOAD is ignored; ld_valid outside LOAD is ignored (ld_ready = 0).
REQ-022 RUN: if_req with if_addr[1:0] == 0 and if_addr[31:AW+2] == 0 drives mem_raddr = if_addr[AW+1:2]; if_valid = 1 next cycle with if_instr = mem_rdata.
REQ-023 RUN: back-to-back requests give one response per cycle, latency exactly 1.
REQ-024 RUN: if_req with misaligned or out-of-range address -> FAULT, fault_addr = if_addr, no response for that request.
REQ-025 FAULT: fault = 1, stall = 1; only ld_start (-> LOAD, fault clears) or rst exits.
REQ-026 RUN: ld_start and if_req in the same cycle -> LOAD; request dropped; a response for the previous cycle's request is still delivered.
REQ-027 if_valid = 0 means if_instr = 32'h0000_0000 (NOP); if_instr never carries stale data.
REQ-028 mem_we only ever asserts in LOAD; no fetch read and write coincide.

Reset
REQ-029 rst: state IDLE, wcnt = 0, len = DEPTH, fault = 0, fault_addr = 0.
REQ-030 rst: outputs ld_ready, ld_done, if_valid, mem_we = 0; if_instr = 0; stall = 1.
REQ-031 rst mid-LOAD aborts the load, no ld_done pulse; memory contents are not cleared.
REQ-032 rst wins over any simultaneous input.

Structure
REQ-033 Shared package holds the state enum, NOP constant 32'h0000_0000, and DEPTH/AW defaults.
REQ-034 Single module; no sub-module; the memory array is external and is not instantiated here.

Verification
REQ-035 Reset, ld_start with ld_len = 4, four words A0..A3 with ld_valid held -> writes at indices 0..3, ld_done one cycle after the last write, state RUN.
REQ-036 RUN, if_req at 0x00, 0x04, 0x08 consecutive cycles -> if_valid on cycles +1..+3 with A0, A1, A2.
REQ-037 if_req at 0x06 -> fault = 1, fault_addr = 0x00000006, stall = 1, no if_valid; then ld_start -> fault clears.
REQ-038 if_req at 0x100 -> FAULT with fault_addr = 0x00000100.
REQ-039 ld_start and if_req same RUN cycle -> LOAD, no response for that request, ld_ready = 1 next cycle.
REQ-040 rst after 2 of 5 load words -> IDLE, no ld_done; then ld_len = 0 loads 64 words, ld_done after index 63.
